// File: rtl/param_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with single-word lines.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module param_cache #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LINES  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              done,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_MISS, WR_THRU, RESP} state_t;
    state_t state, state_nx;

    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              hit_r;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] lines [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             lookup_hit;
    logic             ack;

    assign idx        = addr_r[IDX_W-1:0];
    assign tag        = addr_r[ADDR_W-1:IDX_W];
    assign lookup_hit = valid[idx] && (tags[idx] == tag);
    // An ack arriving while no request is outstanding is ignored.
    assign ack        = mem_req && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        hit      = 1'b0;
        q_valid  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (wr_r)            state_nx = WR_THRU;
                else if (lookup_hit) state_nx = RESP;
                else                 state_nx = RD_MISS;
            end
            RD_MISS, WR_THRU: if (ack) state_nx = RESP;
            RESP: begin
                done     = 1'b1;
                hit      = hit_r;
                q_valid  = !wr_r;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r      <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            hit_r     <= 1'b0;
            valid     <= '0;
            q         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    wr_r   <= wr;
                    addr_r <= addr;
                    data_r <= data;
                end
                LOOKUP: begin
                    hit_r <= lookup_hit;
                    if (!wr_r && lookup_hit) begin
                        q <= lines[idx];
                    end else begin
                        // Every write goes to memory; only read hits skip it.
                        mem_req   <= 1'b1;
                        mem_we    <= wr_r;
                        mem_addr  <= addr_r;
                        mem_wdata <= data_r;
                    end
                end
                RD_MISS: if (ack) begin
                    mem_req    <= 1'b0;
                    valid[idx] <= 1'b1;
                    q          <= mem_rdata;
                end
                WR_THRU: if (ack) mem_req <= 1'b0;
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && wr_r && lookup_hit) begin
            lines[idx] <= data_r;
        end else if (state == RD_MISS && ack) begin
            lines[idx] <= mem_rdata;
            tags[idx]  <= tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESP) begin
            if (hit_r) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: directed scenarios then random traffic checked against
// a memory model plus a valid/tag directory of what the cache should hold.
module tb_param_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wr;
    logic [31:0] addr, data;
    logic        ready, q_valid, done, hit;
    logic [31:0] q;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
    logic        stats_clr;
    logic [31:0] hit_cnt, miss_cnt;
    int          m_hits, m_misses;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    bit          m_valid [32];
    logic [26:0] m_tag   [32];

    always #5 clk = ~clk;

    param_cache #(.DATA_W(32), .ADDR_W(32), .LINES(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .data(data),
        .ready(ready), .q(q), .q_valid(q_valid), .done(done), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
`ifdef CACHE_STATS_EN
        m_hits = 0;
        m_misses = 0;
`endif
    endtask

    // One full transaction; the bench plays the memory with ack after ack_dly idle cycles.
    task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d, input int ack_dly);
        int          idx;
        bit          mhit;
        logic [31:0] exp_q;
        idx  = int'(a[4:0]);
        mhit = m_valid[idx] && (m_tag[idx] == a[31:5]);
        if (!w && !mem.exists(a)) mem[a] = $urandom;
        exp_q = w ? 32'h0 : mem[a];
        @(negedge clk);
        chk("ready_idle", {31'h0, ready}, 32'h1);
        req = 1'b1; wr = w; addr = a; data = d;
        @(negedge clk);
        req = 1'b0; wr = $urandom; addr = $urandom; data = $urandom;
        chk("lookup_quiet", {30'h0, mem_req, done}, 32'h0);
        @(negedge clk);
        if (mhit && !w) begin
            chk("hit_no_memreq", {31'h0, mem_req}, 32'h0);
            chk("hit_done", {29'h0, done, q_valid, hit}, 32'h7);
            chk("hit_q", q, exp_q);
            @(negedge clk);
            chk("hit_ready_back", {30'h0, ready, done}, 32'h2);
        end else begin
            chk("miss_memreq", {30'h0, mem_req, mem_we}, {30'h0, 1'b1, w});
            chk("miss_memaddr", mem_addr, a);
            if (w) chk("wt_wdata", mem_wdata, d);
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                chk("memreq_held", {30'h0, mem_req, done}, 32'h2);
            end
            mem_rdata = w ? $urandom : mem[a];
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk("memreq_drop", {31'h0, mem_req}, 32'h0);
            chk("resp_flags", {29'h0, done, q_valid, hit}, {29'h0, 1'b1, !w, mhit});
            if (!w) chk("miss_q", q, exp_q);
            @(negedge clk);
            chk("resp_ready_back", {30'h0, ready, done}, 32'h2);
        end
        if (w) mem[a] = d;
        else if (!mhit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:5];
        end
`ifdef CACHE_STATS_EN
        if (mhit) m_hits++; else m_misses++;
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
`ifdef CACHE_STATS_EN
        stats_clr = 1'b0;
`endif
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_outs", {28'h0, q_valid, done, hit, mem_req}, 32'h0);
        chk("rst_q", q, 32'h0);
`ifdef CACHE_STATS_EN
        chk("rst_cnts", hit_cnt | miss_cnt, 32'h0);
`endif
        rst_n = 1'b1;

        // Directed scenarios
        mem[32'h0] = 32'h1;
        op(1'b0, 32'h0, 32'h0, 1);            // read miss, fill 1
        op(1'b0, 32'h0, 32'h0, 0);            // read hit
        op(1'b1, 32'h1, 32'h3, 2);            // write miss, no allocate
        op(1'b0, 32'h1, 32'h0, 0);            // still a miss
        mem[32'h20] = 32'hAA;
        op(1'b0, 32'h20, 32'h0, 0);           // conflicting fill on index 0
        op(1'b0, 32'h0, 32'h0, 3);            // evicted: misses again
        op(1'b1, 32'h0, 32'h55, 1);           // write hit, write-through
        op(1'b0, 32'h0, 32'h0, 0);            // hit returns 55

        // Reset while a read miss holds mem_req
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("pre_rst_memreq", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_memreq_drop", {31'h0, mem_req}, 32'h0);
        chk("async_ready", {31'h0, ready}, 32'h1);
`ifdef CACHE_STATS_EN
        chk("rst_cnts2", hit_cnt | miss_cnt, 32'h0);
`endif
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, 32'h0, 32'h0, 0);            // all lines invalid again

`ifdef CACHE_STATS_EN
        op(1'b0, 32'h0, 32'h0, 0);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        m_hits = 0; m_misses = 0;
        chk("clr_cnts", hit_cnt | miss_cnt, 32'h0);
`endif

        // Random traffic over a few tags and indices to mix hits and conflicts
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 5) | $urandom_range(0, 7);
            op(($urandom_range(0, 3) == 0), a, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
